// File: rtl/ym_dbg_capture.sv
// Debug-chain capture engine: strobes a parallel load into an external
// shift chain, then deserialises the chain bits into DATA_WIDTH-bit words
// and hands each word to a single-entry holding register for a consumer.
module ym_dbg_capture #(
  parameter int DATA_WIDTH = 10,
  parameter int WORDS      = 4,
  parameter bit MSB_FIRST  = 1'b0,
  localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  MCLK,
  input  logic                  reset_n,
  input  logic                  c1,
  input  logic                  c2,
  input  logic                  start,
  input  logic                  chain_in,
  output logic                  load,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [IDX_W-1:0]      word_idx,
  output logic                  valid,
  input  logic                  ack,
  output logic                  overflow,
  output logic                  done
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t                state_q, state_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]      word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] sr_shifted;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic                  word_ready;

  // Assembly register with the current chain bit inserted; the direction
  // decides which end of the word the chain delivers first.
  generate
    if (DATA_WIDTH == 1) begin : g_w1
      assign sr_shifted = chain_in;
    end else if (MSB_FIRST) begin : g_msb
      assign sr_shifted = {sr_q[DATA_WIDTH-2:0], chain_in};
    end else begin : g_lsb
      assign sr_shifted = {chain_in, sr_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  // Next-state logic: capture FSM, bit/word counters and holding register.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sr_d       = sr_q;
    valid_d    = valid_q;
    data_d     = data_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    word_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          ovf_d      = 1'b0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          sr_d       = '0;
        end
      end
      S_LOAD: begin
        // The chain latches its parallel data on c1; shifting starts after.
        if (c1) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (c2) begin
          sr_d = sr_shifted;
          if (bit_cnt_q == BIT_LAST) begin
            word_ready = 1'b1;
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == WORD_LAST) begin
              state_d    = S_IDLE;
              done_d     = 1'b1;
              word_cnt_d = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A completed word may replace the held one only if it is free or being
    // consumed this cycle; otherwise the new word is lost and flagged.
    if (word_ready) begin
      if (!valid_q || ack) begin
        valid_d = 1'b1;
        data_d  = sr_shifted;
        idx_d   = word_cnt_q;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && ack) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge MCLK) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sr_q       <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sr_q       <= sr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign load     = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign data_out = data_q;
  assign word_idx = idx_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ym_dbg_capture.sv
// Bench for ym_dbg_capture: two instances (LSB-first and MSB-first, 4-bit
// words, 2 words per capture) driven by the same stimulus and compared every
// cycle against a bit-queue reference model, plus directed scenarios.
module tb_ym_dbg_capture;

  localparam int TB_DW    = 4;
  localparam int TB_WORDS = 2;

  logic clk;
  logic rst_n, start, c1, c2, chain_in, ack;

  logic       load_l, busy_l, valid_l, ovf_l, done_l;
  logic [3:0] data_l;
  logic [0:0] idx_l;
  logic       load_m, busy_m, valid_m, ovf_m, done_m;
  logic [3:0] data_m;
  logic [0:0] idx_m;

  ym_dbg_capture #(.DATA_WIDTH(TB_DW), .WORDS(TB_WORDS), .MSB_FIRST(1'b0)) u_dut_lsb (
    .MCLK(clk), .reset_n(rst_n), .c1(c1), .c2(c2), .start(start),
    .chain_in(chain_in), .load(load_l), .busy(busy_l), .data_out(data_l),
    .word_idx(idx_l), .valid(valid_l), .ack(ack), .overflow(ovf_l), .done(done_l)
  );

  ym_dbg_capture #(.DATA_WIDTH(TB_DW), .WORDS(TB_WORDS), .MSB_FIRST(1'b1)) u_dut_msb (
    .MCLK(clk), .reset_n(rst_n), .c1(c1), .c2(c2), .start(start),
    .chain_in(chain_in), .load(load_m), .busy(busy_m), .data_out(data_m),
    .word_idx(idx_m), .valid(valid_m), .ack(ack), .overflow(ovf_m), .done(done_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;

  // Reference model state: phase 0=idle, 1=load, 2=shift.
  int         m_phase;
  bit         m_bits[$];
  logic       m_valid, m_ovf, m_done;
  logic [3:0] m_data_l, m_data_m;
  logic [0:0] m_idx;

  bit stream [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one clock edge's worth of behaviour from the rules: bits gathered
  // into a queue, words built arithmetically from complete groups.
  task automatic model_step();
    bit new_word;
    int w, wl, wm;
    new_word = 1'b0;
    w = 0; wl = 0; wm = 0;
    if (!rst_n) begin
      m_phase = 0; m_bits.delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
      m_data_l = '0; m_data_m = '0; m_idx = '0;
      return;
    end
    m_done = 1'b0;
    case (m_phase)
      0: if (start) begin m_phase = 1; m_ovf = 1'b0; m_bits.delete(); end
      1: if (c1) m_phase = 2;
      default: begin
        if (c2) begin
          m_bits.push_back(chain_in);
          if (m_bits.size() % TB_DW == 0) begin
            new_word = 1'b1;
            w = m_bits.size() / TB_DW - 1;
            for (int j = 0; j < TB_DW; j++) begin
              if (m_bits[w*TB_DW + j]) begin
                wl += (1 << j);
                wm += (1 << (TB_DW - 1 - j));
              end
            end
            if (w == TB_WORDS - 1) begin m_phase = 0; m_done = 1'b1; end
          end
        end
      end
    endcase
    if (new_word) begin
      if (!m_valid || ack) begin
        m_valid = 1'b1; m_data_l = 4'(wl); m_data_m = 4'(wm); m_idx = 1'(w);
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && ack) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    check_eq("load_lsb",  load_l,  m_phase == 1);
    check_eq("busy_lsb",  busy_l,  m_phase != 0);
    check_eq("valid_lsb", valid_l, m_valid);
    check_eq("data_lsb",  data_l,  m_data_l);
    check_eq("idx_lsb",   idx_l,   m_idx);
    check_eq("ovf_lsb",   ovf_l,   m_ovf);
    check_eq("done_lsb",  done_l,  m_done);
    check_eq("load_msb",  load_m,  m_phase == 1);
    check_eq("busy_msb",  busy_m,  m_phase != 0);
    check_eq("valid_msb", valid_m, m_valid);
    check_eq("data_msb",  data_m,  m_data_m);
    check_eq("idx_msb",   idx_m,   m_idx);
    check_eq("ovf_msb",   ovf_m,   m_ovf);
    check_eq("done_msb",  done_m,  m_done);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (done_l) begin
      n_done++;
      $display("capture %0d done: idx=%0d data_lsb=0x%0h data_msb=0x%0h ovf=%0d t=%0t",
               n_done, idx_l, data_l, data_m, ovf_l, $time);
    end
  endtask

  task automatic drive(input bit st, input bit c1v, input bit c2v, input bit ch, input bit ak);
    start = st; c1 = c1v; c2 = c2v; chain_in = ch; ack = ak;
    cycle();
  endtask

  // Shift the fixed 8-bit stream with a c1 tick between c2 ticks.
  task automatic shift_stream(input bit ak);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 1'b1, stream[i], ak);
      if (i == 3) begin
        check_eq("w0_lsb", data_l, 4'hD);
        check_eq("w0_msb", data_m, 4'hB);
        check_eq("w0_idx", idx_l, 0);
        check_eq("w0_valid", valid_l, 1);
      end
      if (i == 7) begin
        if (ak) begin
          check_eq("w1_lsb", data_l, 4'h4);
          check_eq("w1_msb", data_m, 4'h2);
          check_eq("w1_idx", idx_l, 1);
          check_eq("w1_ovf", ovf_l, 0);
        end else begin
          check_eq("held_lsb", data_l, 4'hD);
          check_eq("held_idx", idx_l, 0);
          check_eq("drop_ovf", ovf_l, 1);
        end
        check_eq("last_done", done_l, 1);
        check_eq("last_busy", busy_l, 0);
      end else begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, ak);
      end
    end
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; c1 = 1'b0; c2 = 1'b0; chain_in = 1'b0; ack = 1'b0;
    m_phase = 0; m_valid = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
    m_data_l = '0; m_data_m = '0; m_idx = '0;

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("rst_busy", busy_l, 0);
    check_eq("rst_data", data_l, 0);
    rst_n = 1'b1;

    // LSB/MSB-first words with ack held high
    d0 = n_done;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("start_load", load_l, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    shift_stream(1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("done_once", n_done - d0, 1);
    check_eq("done_clear", done_l, 0);

    // No ack: second word dropped, overflow sticky until next start
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    shift_stream(1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_sticky", ovf_l, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_cleared", ovf_l, 0);
    check_eq("valid_persist", valid_l, 1);

    // c2 ticks during LOAD are ignored; load ends with the c1 tick
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check_eq("load_hold", load_l, 1);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("load_end", load_l, 0);
    check_eq("shift_busy", busy_l, 1);
    shift_stream(1'b1);

    // Reset after the third c2 tick of a capture
    d0 = n_done;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("abort_busy", busy_l, 0);
    check_eq("abort_valid", valid_l, 0);
    check_eq("abort_load", load_l, 0);
    check_eq("abort_done", done_l, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("abort_no_done", n_done - d0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    shift_stream(1'b1);
    check_eq("after_abort_done", n_done - d0, 1);

    // start held high: back-to-back captures with one idle cycle between
    d0 = n_done;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int cap = 0; cap < 3; cap++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      check_eq("b2b_done", done_l, 1);
      check_eq("b2b_idle", busy_l, 0);
      if (cap < 2) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("b2b_restart", load_l, 1);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("b2b_count", n_done - d0, 3);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int sel;
      sel = $urandom_range(0, 3);
      rst_n = ($urandom_range(0, 299) != 0);
      drive(1'($urandom_range(0, 7) == 0), 1'(sel == 0), 1'(sel == 1),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
